// File: rtl/register_file.sv
// RV32I integer register file: 32 x XLEN, two bypassed combinational read ports,
// one writeback port, and a per-register pending-writer scoreboard for RAW stalls.
module register_file #(
   parameter int XLEN   = 32,
   parameter int PEND_W = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            wb_enable,
   input  logic [4:0]      rs_d,
   input  logic [XLEN-1:0] reg_d,
   input  logic [4:0]      addr_rs1,
   input  logic [4:0]      addr_rs2,
   output logic [XLEN-1:0] data_rs1,
   output logic [XLEN-1:0] data_rs2,
   input  logic            issue_valid,
   input  logic            issue_wb,
   input  logic [4:0]      issue_rd,
   input  logic            flush,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            rd_full
);

   localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

   logic [XLEN-1:0]   regs [32];
   logic [PEND_W-1:0] cnt  [32];

   logic              wb_hit;
   logic              full_raw;
   logic              inc;
   logic              dec;
   logic [PEND_W-1:0] thr1;
   logic [PEND_W-1:0] thr2;

   // Issue handshake: an issue is accepted (counted) only when issue_valid is high
   // and rd_full is low in the same cycle; otherwise decode must hold it.
   assign wb_hit   = wb_enable && (rs_d != 5'd0);
   assign full_raw = issue_wb && (issue_rd != 5'd0) && (cnt[issue_rd] == CNT_MAX);
   assign inc      = issue_valid && issue_wb && (issue_rd != 5'd0) && !full_raw;
   assign dec      = wb_hit && (cnt[rs_d] != '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < 32; r++) begin
            regs[r] <= '0;
            cnt[r]  <= '0;
         end
      end else begin
         if (wb_hit)
            regs[rs_d] <= reg_d;
         if (flush) begin
            for (int r = 0; r < 32; r++)
               cnt[r] <= '0;
         end else begin
            // Matching inc and dec on one register cancel out.
            for (int r = 1; r < 32; r++) begin
               if (inc && issue_rd == 5'(r) && !(dec && rs_d == 5'(r)))
                  cnt[r] <= cnt[r] + PEND_W'(1);
               else if (dec && rs_d == 5'(r) && !(inc && issue_rd == 5'(r)))
                  cnt[r] <= cnt[r] - PEND_W'(1);
            end
         end
      end
   end

   // A writer retiring this cycle is forwarded by the bypass, so it is not a stall.
   assign thr1 = (wb_hit && rs_d == addr_rs1) ? PEND_W'(1) : '0;
   assign thr2 = (wb_hit && rs_d == addr_rs2) ? PEND_W'(1) : '0;

   always_comb begin
      data_rs1 = '0;
      if (!reset && addr_rs1 != 5'd0)
         data_rs1 = (wb_hit && rs_d == addr_rs1) ? reg_d : regs[addr_rs1];
   end

   always_comb begin
      data_rs2 = '0;
      if (!reset && addr_rs2 != 5'd0)
         data_rs2 = (wb_hit && rs_d == addr_rs2) ? reg_d : regs[addr_rs2];
   end

   assign rs1_busy = !reset && (addr_rs1 != 5'd0) && (cnt[addr_rs1] > thr1);
   assign rs2_busy = !reset && (addr_rs2 != 5'd0) && (cnt[addr_rs2] > thr2);
   assign rd_full  = !reset && full_raw;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed cycles push expected outputs into a queue,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_register_file;

   localparam int XLEN = 32;
   localparam int W    = 36;

   localparam logic [3:0] S_D1 = 4'd0;
   localparam logic [3:0] S_D2 = 4'd1;
   localparam logic [3:0] S_B1 = 4'd2;
   localparam logic [3:0] S_B2 = 4'd3;
   localparam logic [3:0] S_FULL = 4'd4;

   logic            clock;
   logic            reset;
   logic            wb_enable;
   logic [4:0]      rs_d;
   logic [XLEN-1:0] reg_d;
   logic [4:0]      addr_rs1;
   logic [4:0]      addr_rs2;
   logic [XLEN-1:0] data_rs1;
   logic [XLEN-1:0] data_rs2;
   logic            issue_valid;
   logic            issue_wb;
   logic [4:0]      issue_rd;
   logic            flush;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            rd_full;

   logic [W-1:0] exp_q[$];
   int compared;
   int mismatched;

   register_file #(.XLEN(XLEN), .PEND_W(2)) dut (
      .clock(clock), .reset(reset),
      .wb_enable(wb_enable), .rs_d(rs_d), .reg_d(reg_d),
      .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
      .data_rs1(data_rs1), .data_rs2(data_rs2),
      .issue_valid(issue_valid), .issue_wb(issue_wb), .issue_rd(issue_rd),
      .flush(flush),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_full(rd_full)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // driver tasks
   task automatic idle();
      reset = 1'b0; wb_enable = 1'b0; rs_d = '0; reg_d = '0;
      addr_rs1 = '0; addr_rs2 = '0;
      issue_valid = 1'b0; issue_wb = 1'b0; issue_rd = '0; flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic chk(input logic [3:0] sel, input logic [31:0] v);
      exp_q.push_back({sel, v});
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] d);
      wb_enable = 1'b1; rs_d = r; reg_d = d;
   endtask

   task automatic issue(input logic [4:0] r);
      issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = r;
   endtask

   // scoreboard monitor
   always @(negedge clock) begin
      logic [W-1:0] e;
      logic [31:0]  act;
      string        name;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e[35:32])
            S_D1:    begin act = data_rs1;          name = "data_rs1"; end
            S_D2:    begin act = data_rs2;          name = "data_rs2"; end
            S_B1:    begin act = {31'b0, rs1_busy}; name = "rs1_busy"; end
            S_B2:    begin act = {31'b0, rs2_busy}; name = "rs2_busy"; end
            default: begin act = {31'b0, rd_full};  name = "rd_full";  end
         endcase
         compared++;
         if (act !== e[31:0]) begin
            mismatched++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, e[31:0]);
         end
      end
   end

   initial begin
      compared = 0;
      mismatched = 0;
      idle();
      reset = 1'b1;
      tick();

      // outputs held at zero while reset is high
      reset = 1'b1; addr_rs1 = 5'd5; wb(5'd5, 32'h1); issue(5'd1);
      chk(S_D1, 32'h0); chk(S_B1, 32'h0); chk(S_FULL, 32'h0);
      tick();

      for (int r = 1; r < 32; r++) begin
         addr_rs1 = 5'(r); addr_rs2 = 5'(32 - r);
         chk(S_D1, 32'h0); chk(S_D2, 32'h0);
         tick();
      end

      // x0 ignores writes and issues
      wb(5'd0, 32'hDEADBEEF); addr_rs1 = 5'd0; chk(S_D1, 32'h0);
      tick();
      issue(5'd0); chk(S_FULL, 32'h0);
      tick();
      addr_rs1 = 5'd0; addr_rs2 = 5'd0;
      chk(S_D1, 32'h0); chk(S_B1, 32'h0); chk(S_B2, 32'h0);
      tick();

      // bypass then array read
      wb(5'd5, 32'h12345678); addr_rs1 = 5'd5; chk(S_D1, 32'h12345678);
      tick();
      addr_rs1 = 5'd5; chk(S_D1, 32'h12345678);
      tick();

      // RAW busy on x7, cleared by same-cycle retirement
      issue(5'd7); addr_rs2 = 5'd7; chk(S_B2, 32'h0);
      tick();
      addr_rs2 = 5'd7; chk(S_B2, 32'h1);
      tick();
      wb(5'd7, 32'hA5); addr_rs2 = 5'd7; chk(S_B2, 32'h0); chk(S_D2, 32'hA5);
      tick();
      addr_rs2 = 5'd7; chk(S_B2, 32'h0); chk(S_D2, 32'hA5);
      tick();

      // saturate x9: cnt 0,1,2 -> full at 3
      for (int i = 0; i < 3; i++) begin
         issue(5'd9); chk(S_FULL, 32'h0);
         tick();
      end
      issue(5'd9); chk(S_FULL, 32'h1);
      tick();
      issue_wb = 1'b1; issue_rd = 5'd9; chk(S_FULL, 32'h1);
      tick();
      // full issue blocked, retirement applies: 3 -> 2; busy since 3 > 1
      issue(5'd9); wb(5'd9, 32'h99); addr_rs1 = 5'd9;
      chk(S_FULL, 32'h1); chk(S_B1, 32'h1); chk(S_D1, 32'h99);
      tick();
      // at 2: issue and retire together leave 2
      issue(5'd9); wb(5'd9, 32'h9A); chk(S_FULL, 32'h0);
      tick();
      issue(5'd9); chk(S_FULL, 32'h0);
      tick();
      issue_wb = 1'b1; issue_rd = 5'd9; chk(S_FULL, 32'h1);
      tick();

      // flush clears pending counters, including a same-cycle issue
      issue(5'd3);
      tick();
      issue(5'd4); addr_rs1 = 5'd3; chk(S_B1, 32'h1);
      tick();
      flush = 1'b1; issue(5'd10); addr_rs1 = 5'd4; chk(S_B1, 32'h1);
      tick();
      addr_rs1 = 5'd3; addr_rs2 = 5'd4; chk(S_B1, 32'h0); chk(S_B2, 32'h0);
      tick();
      addr_rs2 = 5'd10; addr_rs1 = 5'd9; chk(S_B2, 32'h0); chk(S_B1, 32'h0);
      tick();
      wb(5'd3, 32'h33); addr_rs1 = 5'd3; chk(S_B1, 32'h0); chk(S_D1, 32'h33);
      tick();
      addr_rs1 = 5'd3; issue_wb = 1'b1; issue_rd = 5'd3;
      chk(S_D1, 32'h33); chk(S_B1, 32'h0); chk(S_FULL, 32'h0);
      tick();

      // reset mid-stream discards pending state and the concurrent write
      issue(5'd6);
      tick();
      addr_rs1 = 5'd6; chk(S_B1, 32'h1);
      tick();
      reset = 1'b1; wb(5'd6, 32'h55); issue(5'd6); addr_rs1 = 5'd6;
      chk(S_D1, 32'h0); chk(S_B1, 32'h0); chk(S_FULL, 32'h0);
      tick();
      addr_rs1 = 5'd6; addr_rs2 = 5'd5; chk(S_D1, 32'h0); chk(S_B1, 32'h0); chk(S_D2, 32'h0);
      tick();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
      if (exp_q.size() > 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
